mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed 16-bit memory responder with a programmable number of wait states.
// Misaligned or out-of-range accesses complete with err=1, perform no write and return zero data.
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  // state  | meaning
  // IDLE   | waiting for req; ready/err pulse of the previous access is shown here
  // WAITST | counting down wait states for the latched access
  // RESP   | performs the array access; ready/err register on the way back to IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [3:0]  WAIT_M1 = 4'(WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [15:0] mem [DEPTH];

  logic          access_ok;
  logic [IW-1:0] idx;

  assign access_ok = ~addr_q[0] && ({17'd0, addr_q[15:1]} < DEPTH_U);
  assign idx       = addr_q[IW:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = writedata;
          busy_d  = 1'b1;
          if (WAIT > 0) begin
            state_d = WAITST;
            cnt_d   = WAIT_M1;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAITST: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = IDLE;
        if (!access_ok) begin
          err_d   = 1'b1;
          rdata_d = 16'h0000;
        end else if (!we_q) begin
          rdata_d = mem[idx];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Array has no reset; an asynchronous reset drops state_q to IDLE, which cancels any pending write.
  always_ff @(posedge clk) begin
    if (state_q == RESP && access_ok && we_q) begin
      mem[idx] <= wdata_q;
    end
  end

  assign readdata = rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Drives the same access stream into a WAIT=0 and a WAIT=2 responder and checks
// both against a word-array reference model through per-instance response queues.
module tb_mem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    logic [15:0] rd;
    logic        er;
    int          issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;

  logic [15:0] rd_f, rd_s;
  logic        rdy_f, rdy_s, busy_f, busy_s, err_f, err_s;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  exp_t        q_f[$];
  exp_t        q_s[$];
  logic [15:0] mdl [DEPTH];
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] prev_addr = 16'h0000;

  mem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_fast (
    .clk(clk), .reset(rst_n), .req(req), .we(we), .addr(addr), .writedata(wdata),
    .readdata(rd_f), .ready(rdy_f), .busy(busy_f), .err(err_f)
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT(2)) u_slow (
    .clk(clk), .reset(rst_n), .req(req), .we(we), .addr(addr), .writedata(wdata),
    .readdata(rd_s), .ready(rdy_s), .busy(busy_s), .err(err_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: every access either is rejected, writes the array, or reads it.
  task automatic expect_resp(input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int   idx;
    idx = int'(a[15:1]);
    if (a[0] || idx >= DEPTH) begin
      e.er = 1'b1; e.rd = 16'h0000; last_rd = 16'h0000;
    end else if (w) begin
      mdl[idx] = d; e.er = 1'b0; e.rd = last_rd;
    end else begin
      e.rd = mdl[idx]; e.er = 1'b0; last_rd = e.rd;
    end
    e.issue = cyc + 1;
    q_f.push_back(e);
    q_s.push_back(e);
  endtask

  always @(negedge clk) begin : mon_fast
    exp_t e;
    if (rst_n) begin
      if (rdy_f) begin
        if (q_f.size() == 0) begin
          total++; bad++;
          $display("FAIL w0_spurious_ready: got ready=1 expected no response (t=%0t)", $time);
        end else begin
          e = q_f.pop_front();
          chk("w0_readdata", 32'(rd_f), 32'(e.rd));
          chk("w0_err", 32'(err_f), 32'(e.er));
          chk("w0_latency", 32'(cyc - e.issue), 32'd1);
        end
      end else begin
        chk("w0_err_without_ready", 32'(err_f), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_slow
    exp_t e;
    if (rst_n) begin
      if (rdy_s) begin
        if (q_s.size() == 0) begin
          total++; bad++;
          $display("FAIL w2_spurious_ready: got ready=1 expected no response (t=%0t)", $time);
        end else begin
          e = q_s.pop_front();
          chk("w2_readdata", 32'(rd_s), 32'(e.rd));
          chk("w2_err", 32'(err_s), 32'(e.er));
          chk("w2_latency", 32'(cyc - e.issue), 32'd3);
        end
      end else begin
        chk("w2_err_without_ready", 32'(err_s), 32'd0);
      end
    end
  end

  // Caller is in the low clock phase; returns just after the slow instance's ready becomes visible,
  // so a following call issues at the minimum back-to-back interval.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input bit tog);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d;
    expect_resp(w, a, d);
    prev_addr = a;
    @(negedge clk); #1;
    chk("w0_busy_after_req", 32'(busy_f), 32'd1);
    chk("w2_busy_after_req", 32'(busy_s), 32'd1);
    if (tog) begin
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      wdata = 16'($urandom);
    end else begin
      req = 1'b0;
    end
    @(negedge clk); #1;
    req = 1'b0;
    if (tog) begin
      addr = 16'($urandom);
      wdata = 16'($urandom);
    end
    n = 0;
    while (q_s.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (q_s.size() != 0 || q_f.size() != 0) begin
      total++; bad++;
      $display("FAIL response_timeout: got pending w0=%0d w2=%0d expected 0", q_f.size(), q_s.size());
      q_f.delete();
      q_s.delete();
    end
    chk("w2_busy_at_ready", 32'(busy_s), 32'd0);
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 3) return prev_addr;
    if (r == 3) return 16'(2 * $urandom_range(0, 511) + 1);
    if (r == 4) return 16'(512 + 2 * $urandom_range(0, 32000));
    return 16'(2 * $urandom_range(0, DEPTH - 1));
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] d;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ready", 32'(rdy_s), 32'd0);
    chk("reset_busy", 32'(busy_s), 32'd0);
    chk("reset_err", 32'(err_s), 32'd0);
    chk("reset_readdata", 32'(rd_s), 32'd0);
    chk("reset_readdata_w0", 32'(rd_f), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;

    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 0) ? 16'h1111 : (i == 1) ? 16'h2222 : 16'($urandom);
      access(1'b1, 16'(2 * i), d, bit'($urandom_range(0, 1)));
    end

    access(1'b0, 16'h0000, 16'h0000, 1'b0);
    access(1'b0, 16'h0002, 16'h0000, 1'b0);

    access(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);

    access(1'b0, 16'h0003, 16'h0000, 1'b0);
    access(1'b0, 16'h0002, 16'h0000, 1'b1);

    access(1'b1, 16'h0200, 16'hDEAD, 1'b0);
    for (int i = 0; i < DEPTH; i++) access(1'b0, 16'(2 * i), 16'h0000, 1'b1);

    access(1'b1, 16'h0004, 16'hAAAA, 1'b0);
    req = 1'b1; we = 1'b1; addr = 16'h0004; wdata = 16'h5555;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy_s), 32'd0);
    chk("abort_busy_w2", 32'(busy_s), 32'd0);
    chk("abort_busy_w0", 32'(busy_f), 32'd0);
    chk("abort_readdata", 32'(rd_s), 32'd0);
    last_rd = 16'h0000;
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    access(1'b0, 16'h0004, 16'h0000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_gap();
      access(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    #1;
    chk("drain_w0", 32'(q_f.size()), 32'd0);
    chk("drain_w2", 32'(q_s.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
